conv_result_collector: RTL and testbench

CONV_RESULT_COLLECTOR -- requirements
Module: conv_result_collector

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/conv_result_collector.sv | 111 +++++++++++
 tb/tb_conv_result_collector.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution result path: default word width,
// conv-unit latency helper and the collector FSM state type.
package cnn_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_CAPTURE,
        ST_OUTPUT
    } conv_state_t;

    // Accumulation time of the conv unit after its reset is released.
    function automatic int unsigned conv_lat(input int unsigned d, input int unsigned f);
        return d * f * f + 2;
    endfunction

endpackage

// File: rtl/conv_result_collector.sv
// Sequences the conv unit through one window at a time and packs N_OUT
// window results into a single output word with a valid/ready handshake.
module conv_result_collector
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned D          = 1,
    parameter int unsigned F          = 5,
    parameter int unsigned N_OUT      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          win_valid,
    output logic                          win_ready,
    output logic [$clog2(N_OUT):0]        win_idx,
    output logic                          hold_window,
    output logic                          conv_reset,
    input  logic [DATA_WIDTH-1:0]         conv_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_OUT*DATA_WIDTH-1:0]   out_data
);

    localparam int unsigned LAT   = conv_lat(D, F);
    localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int unsigned IDX_W = $clog2(N_OUT) + 1;

    conv_state_t            state, state_next;
    logic [CNT_W-1:0]       cnt;
    logic                   cnt_last;
    logic [DATA_WIDTH-1:0]  slots [N_OUT];

    assign cnt_last = (cnt == CNT_W'(LAT - 1));

    always_comb begin
        state_next  = state;
        win_ready   = 1'b0;
        hold_window = 1'b0;
        out_valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                win_ready = 1'b1;
                if (win_valid)
                    state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                hold_window = 1'b1;
                state_next  = ST_ACCUM;
            end
            ST_ACCUM: begin
                hold_window = 1'b1;
                if (cnt_last)
                    state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                hold_window = 1'b1;
                if (win_idx + IDX_W'(1) == IDX_W'(N_OUT))
                    state_next = ST_OUTPUT;
                else
                    state_next = ST_IDLE;
            end
            ST_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // conv_reset is registered from the next state so it lines up with the
    // state it describes without a combinational path to the conv unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            conv_reset <= 1'b1;
        end else begin
            state      <= state_next;
            conv_reset <= !(state_next == ST_ACCUM || state_next == ST_CAPTURE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            win_idx <= '0;
            for (int unsigned k = 0; k < N_OUT; k++)
                slots[k] <= '0;
        end else begin
            case (state)
                ST_CLEAR: cnt <= '0;
                ST_ACCUM: if (!cnt_last) cnt <= cnt + CNT_W'(1);
                ST_CAPTURE: begin
                    for (int unsigned k = 0; k < N_OUT; k++)
                        if (win_idx == IDX_W'(k))
                            slots[k] <= conv_result;
                    win_idx <= win_idx + IDX_W'(1);
                end
                ST_OUTPUT: if (out_ready) win_idx <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        for (int unsigned k = 0; k < N_OUT; k++)
            out_data[k*DATA_WIDTH +: DATA_WIDTH] = slots[k];
    end

endmodule

// File: tb/tb_conv_result_collector.sv
// Self-checking bench for conv_result_collector at D=1, F=5, N_OUT=4 (LAT=27).
module tb_conv_result_collector;

    localparam int DW    = 16;
    localparam int NOUT  = 4;
    localparam int LAT   = 1 * 5 * 5 + 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             win_valid;
    logic             win_ready;
    logic [2:0]       win_idx;
    logic             hold_window;
    logic             conv_reset;
    logic [DW-1:0]    conv_result;
    logic             out_valid;
    logic             out_ready;
    logic [NOUT*DW-1:0] out_data;

    int n_vectors     = 0;
    int n_miscompares = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mdl   [NOUT];

    conv_result_collector #(
        .DATA_WIDTH (DW),
        .D          (1),
        .F          (5),
        .N_OUT      (NOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_idx     (win_idx),
        .hold_window (hold_window),
        .conv_reset  (conv_reset),
        .conv_result (conv_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_word();
        logic [63:0] w = '0;
        for (int k = 0; k < NOUT; k++)
            w[k*DW +: DW] = mdl[k];
        return w;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lows, ready_viol, hs_n, waited;
        int hs_cyc [$];
        int cyc;
        logic timed_out;

        for (int k = 0; k < NOUT; k++) mdl[k] = '0;
        reset = 1'b1; win_valid = 1'b0; out_ready = 1'b0; conv_result = 16'h1111;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid",  out_valid,  0);
        check("rst_win_ready",  win_ready,  1);
        check("rst_conv_reset", conv_reset, 1);
        check("rst_hold",       hold_window, 0);
        check("rst_win_idx",    win_idx,    0);
        check("rst_out_data",   out_data,   0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", win_ready, 1);

        // Single window: result presented only in the capture cycle
        win_valid = 1'b1;
        @(posedge clk);           // E0
        #1 win_valid = 1'b0;
        @(negedge clk);
        check("clear_conv_reset", conv_reset, 1);
        check("clear_hold",       hold_window, 1);
        check("clear_ready",      win_ready, 0);
        lows = 0; ready_viol = 0;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);       // after E1..E28
            if (conv_reset == 1'b0) lows++;
            if (win_ready) ready_viol++;
            conv_result = (k == LAT + 1) ? 16'h3C00 : 16'h1111;
        end
        @(negedge clk);           // after E29
        conv_result = 16'h2222;
        mdl[0] = 16'h3C00;
        check("single_low_cycles", lows, LAT + 1);
        check("single_ready_viol", ready_viol, 0);
        check("single_conv_reset", conv_reset, 1);
        check("single_ready",      win_ready, 1);
        check("single_hold",       hold_window, 0);
        check("single_win_idx",    win_idx, 1);
        check("single_out_data",   out_data, model_word());

        // Reset in the middle of accumulation (counter = 10)
        win_valid = 1'b1; conv_result = 16'hDEAD;
        @(posedge clk);           // E0
        #1 win_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < NOUT; k++) mdl[k] = '0;
        #1;
        check("midrst_win_idx",    win_idx, 0);
        check("midrst_out_data",   out_data, 0);
        check("midrst_conv_reset", conv_reset, 1);
        check("midrst_hold",       hold_window, 0);
        check("midrst_out_valid",  out_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", win_ready, 1);

        // Continuous win_valid: four windows, handshakes every LAT+3 cycles
        win_valid = 1'b1;
        cyc = 0; hs_n = 0;
        while (hs_n < NOUT && cyc < 400) begin
            if (win_ready) begin
                conv_result = DW'(hs_n + 1);
                exp_q.push_back(DW'(hs_n + 1));
                hs_cyc.push_back(cyc);
                hs_n++;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("stream_hs_count", hs_n, NOUT);
        for (int i = 1; i < hs_cyc.size(); i++)
            check($sformatf("stream_hs_gap%0d", i), hs_cyc[i] - hs_cyc[0], i * (LAT + 3));

        waited = 0; timed_out = 1'b1;
        while (waited < 60) begin
            if (out_valid) begin timed_out = 1'b0; break; end
            @(negedge clk);
            waited++;
        end
        check("out_valid_timeout", timed_out, 0);
        for (int k = 0; k < NOUT; k++)
            mdl[k] = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hXXXX;
        check("out_word", out_data, model_word());
        check("out_win_idx", win_idx, NOUT);

        // Backpressure: word held, no window accepted
        conv_result = 16'h0005;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("hold_valid%0d", k), out_valid, 1);
            check($sformatf("hold_data%0d", k),  out_data, model_word());
            check($sformatf("hold_ready%0d", k), win_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_valid",   out_valid, 0);
        check("drain_win_idx", win_idx, 0);
        check("drain_ready",   win_ready, 1);
        check("drain_data",    out_data, model_word());

        // Next window overwrites slot 0 only; other slots keep their results
        waited = 0; timed_out = 1'b1;
        while (waited < 60) begin
            @(negedge clk);
            waited++;
            if (win_idx == 3'd1) begin timed_out = 1'b0; break; end
        end
        win_valid = 1'b0;
        mdl[0] = 16'h0005;
        check("next_timeout",  timed_out, 0);
        check("next_wait",     waited, LAT + 3);
        check("next_out_data", out_data, model_word());
        check("next_ready",    win_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
